// File: rtl/mpc_dot_acc_sat_if.sv
// Operand-tag / product / result bundle between the MPC multiplier, the
// dot-product accumulator and its consumer.
interface mpc_dot_acc_sat_if #(
    parameter int unsigned P_W   = 30,
    parameter int unsigned OUT_W = 21
) ();
    logic                    in_valid;
    logic                    in_last;
    logic signed [P_W-1:0]   p;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;
    logic                    out_cnt_err;

    modport master (
        output in_valid, in_last, p,
        input  out_valid, out_data, out_sat, out_cnt_err
    );

    modport slave (
        input  in_valid, in_last, p,
        output out_valid, out_data, out_sat, out_cnt_err
    );
endinterface

// File: rtl/mpc_dot_acc_sat.sv
// Dot-product accumulator behind the 21s x 9s multiplier: latency-matched tag
// line, wrapping accumulate, then round-half-up, rescale and saturate to 21 bits.
module mpc_dot_acc_sat #(
    parameter int unsigned P_W        = 30,
    parameter int unsigned OUT_W      = 21,
    parameter int unsigned ACC_W      = 36,
    parameter int unsigned MUL_LAT    = 3,
    parameter int unsigned FRAC_SHIFT = 8,
    parameter int unsigned MAX_TERMS  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    mpc_dot_acc_sat_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(MAX_TERMS + 2);
    localparam int unsigned R_W   = ACC_W + 1 - FRAC_SHIFT;

    localparam logic [ACC_W:0]          RND_HALF = (ACC_W+1)'(2 ** (FRAC_SHIFT - 1));
    localparam logic signed [R_W-1:0]   MAX_R    = R_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [R_W-1:0]   MIN_R    = ~MAX_R;
    localparam logic signed [OUT_W-1:0] MAX_OUT  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_OUT  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0]        CNT_TOP  = CNT_W'(MAX_TERMS + 1);

    logic [MUL_LAT-1:0]      vt_q, vt_d, lt_q, lt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    first_q, first_d;
    logic                    err_q, err_d;
    logic signed [ACC_W-1:0] fin_sum_q, fin_sum_d;
    logic                    fin_err_q, fin_err_d;
    logic                    fin_v_q, fin_v_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic                    out_cnt_err_q, out_cnt_err_d;

    logic                    al_v_c, al_l_c;
    logic signed [ACC_W-1:0] p_ext_c, acc_next_c;
    logic [CNT_W-1:0]        cnt_next_c;
    logic                    err_next_c;
    logic [ACC_W:0]          rnd_sum_c;
    logic signed [R_W-1:0]   rnd_c;
    logic                    sat_hi_c, sat_lo_c;
    logic signed [OUT_W-1:0] clip_c;

    // Tag delay line; only ce edges advance it, mirroring the multiplier pipe
    always_comb begin
        vt_d = vt_q;
        lt_d = lt_q;
        if (ce) begin
            vt_d[0] = bus.in_valid;
            lt_d[0] = bus.in_valid & bus.in_last;
            for (int unsigned k = 1; k < MUL_LAT; k++) begin
                vt_d[k] = vt_q[k-1];
                lt_d[k] = lt_q[k-1];
            end
        end
    end

    assign al_v_c = vt_q[MUL_LAT-1];
    assign al_l_c = lt_q[MUL_LAT-1];

    // Per-term arithmetic; count saturates one past the limit so it cannot wrap
    always_comb begin
        p_ext_c    = {{(ACC_W-P_W){bus.p[P_W-1]}}, bus.p};
        acc_next_c = (first_q ? '0 : acc_q) + p_ext_c;
        if (first_q)
            cnt_next_c = CNT_W'(1);
        else if (cnt_q == CNT_TOP)
            cnt_next_c = cnt_q;
        else
            cnt_next_c = cnt_q + CNT_W'(1);
        err_next_c = (first_q ? 1'b0 : err_q) | (cnt_next_c > CNT_MAX);
    end

    // Round half toward +inf, rescale by taking the upper bits, then clip
    always_comb begin
        rnd_sum_c = {fin_sum_q[ACC_W-1], fin_sum_q} + RND_HALF;
        rnd_c     = rnd_sum_c[ACC_W:FRAC_SHIFT];
        sat_hi_c  = rnd_c > MAX_R;
        sat_lo_c  = rnd_c < MIN_R;
        if (sat_hi_c)
            clip_c = MAX_OUT;
        else if (sat_lo_c)
            clip_c = MIN_OUT;
        else
            clip_c = rnd_c[OUT_W-1:0];
    end

    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        first_d       = first_q;
        err_d         = err_q;
        fin_sum_d     = fin_sum_q;
        fin_err_d     = fin_err_q;
        fin_v_d       = fin_v_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sat_d     = out_sat_q;
        out_cnt_err_d = out_cnt_err_q;
        if (ce) begin
            fin_v_d = 1'b0;
            if (al_v_c) begin
                acc_d   = acc_next_c;
                cnt_d   = cnt_next_c;
                first_d = al_l_c;
                err_d   = al_l_c ? 1'b0 : err_next_c;
                if (al_l_c) begin
                    fin_sum_d = acc_next_c;
                    fin_err_d = err_next_c;
                    fin_v_d   = 1'b1;
                end
            end
            out_valid_d = fin_v_q;
            if (fin_v_q) begin
                out_data_d    = clip_c;
                out_sat_d     = sat_hi_c | sat_lo_c;
                out_cnt_err_d = fin_err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vt_q          <= '0;
            lt_q          <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            first_q       <= 1'b1;
            err_q         <= 1'b0;
            fin_sum_q     <= '0;
            fin_err_q     <= 1'b0;
            fin_v_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sat_q     <= 1'b0;
            out_cnt_err_q <= 1'b0;
        end else begin
            vt_q          <= vt_d;
            lt_q          <= lt_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            first_q       <= first_d;
            err_q         <= err_d;
            fin_sum_q     <= fin_sum_d;
            fin_err_q     <= fin_err_d;
            fin_v_q       <= fin_v_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sat_q     <= out_sat_d;
            out_cnt_err_q <= out_cnt_err_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_sat     = out_sat_q;
    assign bus.out_cnt_err = out_cnt_err_q;

endmodule

// File: tb/tb_mpc_dot_acc_sat.sv
// Scoreboard bench: a ce-gated 3-stage multiplier model feeds p, directed
// vectors push hand-computed results, a negedge monitor pops and compares.
module tb_mpc_dot_acc_sat;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    mpc_dot_acc_sat_if bus ();

    mpc_dot_acc_sat dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product of the operands presented this cycle,
    // visible on p after three ce edges.
    logic signed [29:0] prod_in, m0, m1, m2;
    always @(posedge clk) begin
        if (ce) begin
            m0 <= prod_in;
            m1 <= m0;
            m2 <= m1;
        end
    end
    assign bus.p = m2;

    typedef struct packed {
        logic signed [20:0] d;
        logic               s;
        logic               e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input int d, input logic s, input logic e);
        exp_t x;
        x.d = 21'(d);
        x.s = s;
        x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic step(input logic v, input logic l, input int pr, input logic c);
        bus.in_valid = v;
        bus.in_last  = l;
        prod_in      = v ? 30'(pr) : 30'($urandom);
        ce           = c;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input int n, input int pr);
        for (int i = 0; i < n; i++) step(1'b1, i == n - 1, pr, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b1);
    endtask

    // Monitor: one result per ce edge at which out_valid is presented
    always @(negedge clk) begin
        if (rst && ce && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("out_data", int'(bus.out_data), int'($signed(x.d)));
                chk("out_sat", int'(bus.out_sat), int'(x.s));
                chk("out_cnt_err", int'(bus.out_cnt_err), int'(x.e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst          = 1'b0;
        ce           = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        prod_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_sat", int'(bus.out_sat), 0);
        chk("rst_out_cnt_err", int'(bus.out_cnt_err), 0);
        rst = 1'b1;
        idle(4);

        // 4 x 768 = 3072 -> 12
        push(12, 1'b0, 1'b0);
        vec(4, 768);
        idle(8);

        // Rounding on single-term vectors
        push(1, 1'b0, 1'b0);  vec(1, 128);
        push(0, 1'b0, 1'b0);  vec(1, -128);
        push(-1, 1'b0, 1'b0); vec(1, -129);
        idle(8);

        // Saturation both ways
        push(1048575, 1'b1, 1'b0);  vec(2, 1 << 28);
        push(-1048576, 1'b1, 1'b0); vec(1, -(1 << 29));
        idle(8);

        // ce stall mid-vector and mid-output
        push(3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 256, 1'b1);
        step(1'b1, 1'b0, 256, 1'b1);
        repeat (5) step(1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 256, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 0, 1'b1);
        end
        chk("stall_out_valid_seen", int'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold_valid", int'(bus.out_valid), 1);
            chk("stall_hold_data", int'(bus.out_data), 3);
            step(1'b0, 1'b0, 0, 1'b0);
        end
        step(1'b0, 1'b0, 0, 1'b1);
        chk("stall_valid_one_edge", int'(bus.out_valid), 0);
        idle(8);

        // Back-to-back: A (2 x 512), B (65 x 256, count error), then clean C
        push(4, 1'b0, 1'b0);
        push(65, 1'b0, 1'b1);
        push(1, 1'b0, 1'b0);
        vec(2, 512);
        vec(65, 256);
        vec(1, 256);
        idle(8);

        // Reset mid-vector: aborted terms must not produce or pollute output
        step(1'b1, 1'b0, 256, 1'b1);
        step(1'b1, 1'b0, 256, 1'b1);
        rst = 1'b0;
        step(1'b0, 1'b0, 0, 1'b1);
        rst = 1'b1;
        push(1, 1'b0, 1'b0);
        vec(1, 256);
        idle(10);

        chk("pending_results", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
